// File: rtl/rggen_lock_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rggen_lock_ctrl_pkg                                         |
// | Brief  : Shared types and helpers for the key-sequence lock ctrl.    |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package rggen_lock_ctrl_pkg;

  typedef enum logic [1:0] {
    LOCKED    = 2'd0,
    KEY1_WAIT = 2'd1,
    UNLOCKED  = 2'd2,
    HARD      = 2'd3
  } rggen_lock_state_e;

  // Error counter width: enough to hold ERROR_LIMIT, never narrower than 1 bit.
  function automatic int calc_ecw(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : rggen_lock_ctrl_pkg
`default_nettype wire

// File: rtl/rggen_lock_ctrl_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rggen_lock_ctrl_timer                                       |
// | Brief  : Unlock-window down counter: loads on entry, counts while    |
// |          active, flags expiry in the last active cycle.              |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module rggen_lock_ctrl_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_active,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_load_val = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Load on entry, decrement while unlocked, park at zero otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= c_load_val;
    end else if (i_active && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end else if (!i_active) begin
      r_count <= '0;
    end
  end

  // Zero while active means this is the final unlocked cycle.
  assign o_expired = i_active && (r_count == '0);

endmodule : rggen_lock_ctrl_timer
`default_nettype wire

// File: rtl/rggen_lock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rggen_lock_ctrl                                             |
// | Brief  : Key-sequence lock controller driving i_lock of rwl fields.  |
// |          Optional unlock timeout: define RGGEN_LOCK_CTRL_TIMEOUT_EN. |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module rggen_lock_ctrl
  import rggen_lock_ctrl_pkg::*;
#(
  parameter int                   KEY_WIDTH   = 32,
  parameter logic [KEY_WIDTH-1:0] KEY0        = 32'h0000_C0DE,
  parameter logic [KEY_WIDTH-1:0] KEY1        = 32'h0000_FACE,
  parameter bit                   ONE_SHOT    = 1'b1,
  parameter int                   ERROR_LIMIT = 4,
  parameter int                   TIMEOUT     = 256,
  localparam int                  ECW         = calc_ecw(ERROR_LIMIT)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_key_valid,
  input  logic [KEY_WIDTH-1:0] i_key_data,
  input  logic                 i_lock_req,
  input  logic                 i_field_write,
  output logic                 o_lock,
  output logic                 o_key_error,
  output logic                 o_hard_lock,
  output logic [ECW-1:0]       o_error_count
);

  localparam logic [ECW-1:0] c_err_limit = ECW'(ERROR_LIMIT);

  if (KEY0 == KEY1) begin : g_key_conflict
    $error("rggen_lock_ctrl: KEY0 and KEY1 must differ");
  end

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("rggen_lock_ctrl: TIMEOUT must be at least 1");
  end

  rggen_lock_state_e r_state;
  rggen_lock_state_e w_state_nxt;
  logic              w_bad_key;
  logic              w_unlock;
  logic              w_timeout;
  logic [ECW-1:0]    w_cnt_inc;
  logic [ECW-1:0]    r_err_cnt;
  logic              r_lock;
  logic              r_key_error;
  logic              r_hard_lock;

`ifdef RGGEN_LOCK_CTRL_TIMEOUT_EN
  logic w_timer_load;
  assign w_timer_load = (w_state_nxt == UNLOCKED) && (r_state != UNLOCKED);

  rggen_lock_ctrl_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_timer_load),
    .i_active  (r_state == UNLOCKED),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Saturating increment of the consecutive bad-key count.
  assign w_cnt_inc = (r_err_cnt == c_err_limit) ? r_err_cnt : r_err_cnt + 1'b1;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= LOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; bad keys that reach the limit divert straight to HARD.
  always_comb begin
    w_state_nxt = r_state;
    w_bad_key   = 1'b0;
    w_unlock    = 1'b0;
    case (r_state)
      LOCKED: begin
        if (i_key_valid) begin
          if (i_key_data == KEY0) w_state_nxt = KEY1_WAIT;
          else                    w_bad_key   = 1'b1;
        end
      end
      KEY1_WAIT: begin
        // A relock request wins over a simultaneous key write and never counts as an error.
        if (i_lock_req) begin
          w_state_nxt = LOCKED;
        end else if (i_key_valid) begin
          if (i_key_data == KEY1) begin
            w_state_nxt = UNLOCKED;
            w_unlock    = 1'b1;
          end else if (i_key_data != KEY0) begin
            w_state_nxt = LOCKED;
            w_bad_key   = 1'b1;
          end
        end
      end
      UNLOCKED: begin
        if (i_lock_req || i_key_valid || (ONE_SHOT && i_field_write) || w_timeout) begin
          w_state_nxt = LOCKED;
        end
      end
      HARD:    w_state_nxt = HARD;
      default: w_state_nxt = LOCKED;
    endcase
    if (w_bad_key && (ERROR_LIMIT != 0) && (w_cnt_inc == c_err_limit)) begin
      w_state_nxt = HARD;
    end
  end

  // Error counter: cleared by a successful unlock, bumped by each bad key.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_cnt <= '0;
    end else if (w_unlock) begin
      r_err_cnt <= '0;
    end else if (w_bad_key) begin
      r_err_cnt <= w_cnt_inc;
    end
  end

  // Output registers follow the next state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock      <= 1'b1;
      r_key_error <= 1'b0;
      r_hard_lock <= 1'b0;
    end else begin
      r_lock      <= (w_state_nxt != UNLOCKED);
      r_key_error <= w_bad_key;
      r_hard_lock <= (w_state_nxt == HARD);
    end
  end

  assign o_lock        = r_lock;
  assign o_key_error   = r_key_error;
  assign o_hard_lock   = r_hard_lock;
  assign o_error_count = r_err_cnt;

endmodule : rggen_lock_ctrl
`default_nettype wire

// File: tb/tb_rggen_lock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_rggen_lock_ctrl                                          |
// | Brief  : Directed self-checking bench for rggen_lock_ctrl.           |
// |          Timeout checks follow RGGEN_LOCK_CTRL_TIMEOUT_EN.           |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_rggen_lock_ctrl;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [31:0] key_data;
  logic        lock_req;
  logic        field_write;
  logic        lock;
  logic        key_error;
  logic        hard_lock;
  logic [2:0]  error_count;

  int n_checks;
  int n_fail;

  rggen_lock_ctrl #(
    .KEY_WIDTH   (32),
    .KEY0        (32'h0000_C0DE),
    .KEY1        (32'h0000_FACE),
    .ONE_SHOT    (1'b1),
    .ERROR_LIMIT (4),
    .TIMEOUT     (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_key_valid   (key_valid),
    .i_key_data    (key_data),
    .i_lock_req    (lock_req),
    .i_field_write (field_write),
    .o_lock        (lock),
    .o_key_error   (key_error),
    .o_hard_lock   (hard_lock),
    .o_error_count (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [31:0] d);
    key_valid = 1'b1;
    key_data  = d;
    tick();
    key_valid = 1'b0;
    key_data  = '0;
  endtask

  task automatic pulse_lock_req();
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic l, input logic e,
                           input logic h, input logic [2:0] c);
    check_eq({tag, "_lock"},  {31'd0, lock},       {31'd0, l});
    check_eq({tag, "_kerr"},  {31'd0, key_error},  {31'd0, e});
    check_eq({tag, "_hard"},  {31'd0, hard_lock},  {31'd0, h});
    check_eq({tag, "_count"}, {29'd0, error_count}, {29'd0, c});
  endtask

  initial begin
    int unlocked_leaks;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    key_valid   = 1'b0;
    key_data    = '0;
    lock_req    = 1'b0;
    field_write = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_all("reset", 1'b1, 1'b0, 1'b0, 3'd0);

    // Basic unlock sequence
    write_key(32'h0000_C0DE);
    check_all("t1_key0", 1'b1, 1'b0, 1'b0, 3'd0);
    write_key(32'h0000_FACE);
    check_all("t1_key1", 1'b0, 1'b0, 1'b0, 3'd0);

    // One-shot relock on a field write
    field_write = 1'b1;
    tick();
    field_write = 1'b0;
    check_all("t2_fw", 1'b1, 1'b0, 1'b0, 3'd0);
    write_key(32'h0000_C0DE);
    write_key(32'h0000_FACE);
    check_eq("t2_unlock2", {31'd0, lock}, 32'd0);
    lock_req    = 1'b1;
    field_write = 1'b1;
    tick();
    lock_req    = 1'b0;
    field_write = 1'b0;
    check_all("t2_req_fw", 1'b1, 1'b0, 1'b0, 3'd0);
    // Any key write while unlocked relocks without an error
    write_key(32'h0000_C0DE);
    write_key(32'h0000_FACE);
    write_key(32'h0000_1234);
    check_all("t2_keyrelock", 1'b1, 1'b0, 1'b0, 3'd0);

    // Three bad keys, then a clean unlock clears the count
    write_key(32'h1);
    check_all("t3_bad1", 1'b1, 1'b1, 1'b0, 3'd1);
    write_key(32'h2);
    check_all("t3_bad2", 1'b1, 1'b1, 1'b0, 3'd2);
    write_key(32'h3);
    check_all("t3_bad3", 1'b1, 1'b1, 1'b0, 3'd3);
    tick();
    check_all("t3_idle", 1'b1, 1'b0, 1'b0, 3'd3);
    write_key(32'h0000_C0DE);
    check_all("t3_key0", 1'b1, 1'b0, 1'b0, 3'd3);
    write_key(32'h0000_FACE);
    check_all("t3_unlock", 1'b0, 1'b0, 1'b0, 3'd0);
    pulse_lock_req();
    check_all("t3_relock", 1'b1, 1'b0, 1'b0, 3'd0);

    // KEY1_WAIT: repeated KEY0 restarts, wrong second key is an error
    write_key(32'h0000_C0DE);
    write_key(32'h0000_C0DE);
    check_all("t5_restart", 1'b1, 1'b0, 1'b0, 3'd0);
    write_key(32'h0000_FACE);
    check_all("t5_unlock", 1'b0, 1'b0, 1'b0, 3'd0);
    pulse_lock_req();
    write_key(32'h0000_C0DE);
    write_key(32'h0000_1234);
    check_all("t5_badk1", 1'b1, 1'b1, 1'b0, 3'd1);
    // Back in LOCKED: KEY1 alone is a bad key
    write_key(32'h0000_FACE);
    check_all("t5_lonekey1", 1'b1, 1'b1, 1'b0, 3'd2);
    // lock_req in KEY1_WAIT returns to LOCKED quietly
    write_key(32'h0000_C0DE);
    pulse_lock_req();
    write_key(32'h0000_FACE);
    check_all("t5_reqwait", 1'b1, 1'b1, 1'b0, 3'd3);
    write_key(32'h0000_C0DE);
    write_key(32'h0000_FACE);
    check_all("t5_unlock2", 1'b0, 1'b0, 1'b0, 3'd0);
    pulse_lock_req();

    // Four bad keys escalate to hard lock
    write_key(32'h11);
    write_key(32'h22);
    write_key(32'h33);
    check_all("t4_bad3", 1'b1, 1'b1, 1'b0, 3'd3);
    write_key(32'h44);
    check_all("t4_hard", 1'b1, 1'b1, 1'b1, 3'd4);
    write_key(32'h0000_C0DE);
    check_all("t4_hkey0", 1'b1, 1'b0, 1'b1, 3'd4);
    write_key(32'h0000_FACE);
    check_all("t4_hkey1", 1'b1, 1'b0, 1'b1, 3'd4);
    write_key(32'h55);
    check_all("t4_hbad", 1'b1, 1'b0, 1'b1, 3'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("t4_reset", 1'b1, 1'b0, 1'b0, 3'd0);
    write_key(32'h0000_C0DE);
    write_key(32'h0000_FACE);
    check_all("t4_post", 1'b0, 1'b0, 1'b0, 3'd0);

    // Unlocked window length
`ifdef RGGEN_LOCK_CTRL_TIMEOUT_EN
    for (int i = 2; i <= 8; i++) begin
      tick();
      check_eq($sformatf("t6_open%0d", i), {31'd0, lock}, 32'd0);
    end
    tick();
    check_eq("t6_expire", {31'd0, lock}, 32'd1);
`else
    unlocked_leaks = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (lock !== 1'b0) unlocked_leaks++;
    end
    check_eq("t6_persist", unlocked_leaks, 32'd0);
    pulse_lock_req();
    check_eq("t6_relock", {31'd0, lock}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rggen_lock_ctrl
`default_nettype wire
